// File: rtl/four_bit_cla_adder_pkg.sv
// Shared constants and result type for the 4-bit carry-lookahead adder leaf cell.
package four_bit_cla_adder_pkg;

    localparam int CLA_WIDTH = 4;

    typedef struct packed {
        logic                 c4;
        logic [CLA_WIDTH-1:0] sum;
    } cla_result_t;

endpackage

// File: rtl/four_bit_cla_adder_carry_unit.sv
// Two-level lookahead carry network over 4 bit positions, also producing group P/G
// so it can sit unchanged in a second-level lookahead tree.
module cla_carry_unit
    import four_bit_cla_adder_pkg::*;
(
    input  logic [CLA_WIDTH-1:0] p,
    input  logic [CLA_WIDTH-1:0] g,
    input  logic                 c0,
    output logic [CLA_WIDTH:1]   c,
    output logic                 grp_p,
    output logic                 grp_g
);

    // Each carry is a flat sum-of-products of c0, g and p; nothing ripples.
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);
    assign c[4] = grp_g | (grp_p & c0);

    assign grp_p = p[3] & p[2] & p[1] & p[0];
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/four_bit_cla_adder.sv
// 4-bit carry-lookahead adder with a one-cycle registered output stage and
// exported group propagate/generate.
module four_bit_cla_adder
    import four_bit_cla_adder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [CLA_WIDTH-1:0] a,
    input  logic [CLA_WIDTH-1:0] b,
    input  logic                 c0,
    output logic                 out_valid,
    output logic [CLA_WIDTH-1:0] sum,
    output logic                 c4,
    output logic                 grp_p,
    output logic                 grp_g
);

    localparam int WIDTH = CLA_WIDTH;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:1]   c;
    logic             grp_p_d;
    logic             grp_g_d;
    cla_result_t      res_d;
    cla_result_t      res_q;

    assign p = a ^ b;
    assign g = a & b;

    cla_carry_unit u_carry (
        .p     (p),
        .g     (g),
        .c0    (c0),
        .c     (c),
        .grp_p (grp_p_d),
        .grp_g (grp_g_d)
    );

    assign res_d.sum = p ^ {c[WIDTH-1:1], c0};
    assign res_d.c4  = c[WIDTH];

    // Result registers only load on accepted operations; valid drops otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res_q     <= '0;
            grp_p     <= 1'b0;
            grp_g     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
                grp_p <= grp_p_d;
                grp_g <= grp_g_d;
            end
        end
    end

    assign sum = res_q.sum;
    assign c4  = res_q.c4;

endmodule

// File: tb/tb_four_bit_cla_adder.sv
// Scoreboard bench for four_bit_cla_adder: driver pushes expected results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_four_bit_cla_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       c0;
    logic       out_valid;
    logic [3:0] sum;
    logic       c4;
    logic       grp_p;
    logic       grp_g;

    typedef struct {
        logic [3:0] sum;
        logic       c4;
        logic       gp;
        logic       gg;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    four_bit_cla_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c0        (c0),
        .out_valid (out_valid),
        .sum       (sum),
        .c4        (c4),
        .grp_p     (grp_p),
        .grp_g     (grp_g)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compare each presented result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid: got sum=%0d c4=%0b with no pending op", sum, c4);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (sum !== e.sum || c4 !== e.c4 || grp_p !== e.gp || grp_g !== e.gg) begin
                    failures++;
                    $display("FAIL %s: got sum=%0d c4=%0b gp=%0b gg=%0b want sum=%0d c4=%0b gp=%0b gg=%0b",
                             e.nm, sum, c4, grp_p, grp_g, e.sum, e.c4, e.gp, e.gg);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
        end
    endtask

    task automatic op(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                      input logic [3:0] es, input logic ec4, input logic egp,
                      input logic egg, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        a = ta; b = tb; c0 = tc; in_valid = 1'b1;
        e.sum = es; e.c4 = ec4; e.gp = egp; e.gg = egg; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [4:0] s5;
        logic [4:0] ab;
        int         waited;
        checks   = 0;
        failures = 0;
        in_valid = 1'b0;
        a = 4'd0; b = 4'd0; c0 = 1'b0;
        rst_n = 1'b1;

        // Reset asserted with operands applied, checked before any clock edge.
        #1;
        rst_n = 1'b0;
        a = 4'd15; b = 4'd14; in_valid = 1'b1;
        #2;
        check("reset_outputs", {3'b0, out_valid, sum}, 8'h00);
        check("reset_flags", {6'b0, c4, grp_p | grp_g}, 8'h00);
        in_valid = 1'b0;
        #9;
        rst_n = 1'b1;

        // Back-to-back directed vectors.
        op(4'd15, 4'd14, 1'b0, 4'd13, 1'b1, 1'b0, 1'b1, "dir_15_14");
        op(4'd15, 4'd13, 1'b0, 4'd12, 1'b1, 1'b0, 1'b1, "dir_15_13");
        op(4'd15, 4'd12, 1'b0, 4'd11, 1'b1, 1'b0, 1'b1, "dir_15_12");

        // Hold: operands change with in_valid low; registers must keep 11/1.
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 4'd3; b = 4'd4; c0 = 1'b1;
        @(posedge clk);
        #1;
        check("hold_sum_c4", {3'b0, c4, sum}, {3'b0, 1'b1, 4'd11});
        check("hold_out_valid", {7'b0, out_valid}, 8'h00);

        op(4'd10, 4'd5, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, "full_prop_c1");
        op(4'd10, 4'd5, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, "full_prop_c0");
        op(4'd8,  4'd8, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, "gen_8_8");
        op(4'd0,  4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, "zero");
        op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1, "max_31");
        idle();
        idle();

        // Mid-operation reset: result visible, then cleared between edges.
        op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1, "midrst_op");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("midrst_pre", {2'b0, out_valid, c4, sum}, {2'b0, 1'b1, 1'b1, 4'd15});
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_cleared", {3'b0, out_valid, sum}, 8'h00);
        check("midrst_flags", {5'b0, c4, grp_p, grp_g}, 8'h00);
        #1;
        rst_n = 1'b1;
        idle();

        // Exhaustive sweep against the arithmetic reference.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    s5 = 5'(ia) + 5'(ib) + 5'(ic);
                    ab = 5'(ia) + 5'(ib);
                    op(4'(ia), 4'(ib), 1'(ic), s5[3:0], s5[4],
                       ((4'(ia) ^ 4'(ib)) == 4'hF), (ab > 5'd15), "exhaustive");
                end
            end
        end
        idle();

        waited = 0;
        while (sb.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("drain_pending", 8'(sb.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
